// File: rtl/chip_serial_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chip_if_pkg
// Purpose  : Shared definitions for the chip configuration link receiver:
//            default field widths, error-cause codes and FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package chip_if_pkg;

    localparam int DEF_ADDR_W  = 3;
    localparam int DEF_LEVEL_W = 8;
    localparam int NUM_DAC     = 8;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_STOP    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ADDR  = 3'd2,
        ST_LEVEL = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // True while a frame is partially received; only these states can be
    // aborted by a link reset or expire on a stalled link clock.
    function automatic logic in_frame(input state_t s);
        return (s == ST_ADDR) || (s == ST_LEVEL) || (s == ST_STOP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/chip_serial_rx_sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Purpose  : Multi-stage synchronizer for one asynchronous input, plus a
//            registered one-cycle pulse on each falling edge of the
//            synchronized value.
// Ports    : clk  - system clock
//            rst  - asynchronous active-high reset (chain clears to 0)
//            d    - asynchronous input
//            q    - synchronized level (STAGES cycles of latency)
//            fall - one-cycle pulse, one cycle after q goes 1 -> 0
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_det #(
    parameter int STAGES = 2    // must be at least 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
        fall_d = prev_q & ~sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            fall_q <= fall_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign fall = fall_q;

endmodule
`default_nettype wire

// File: rtl/chip_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : chip_serial_rx
// Purpose  : Oversampling receiver for the three-wire chip configuration
//            link. Decodes DAC write frames (start, addr LSB-first, level
//            LSB-first, stop), keeps a shadow of all eight DAC levels and
//            reports stop-bit, timeout and link-reset abort errors.
// Ports    : clk, rst                 - system clock, async active-high reset
//            chip_clk, chip_rst,
//            chip_data_in             - asynchronous link inputs
//            frame_valid/frame_err    - one-cycle result pulses
//            frame_addr/frame_level   - last good frame
//            err_code                 - cause, valid with frame_err
//            in_reset                 - synchronized chip_rst is low
//            shadow_levels            - DAC n at [LEVEL_W*n +: LEVEL_W]
//            frame_count              - good-frame counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module chip_serial_rx
    import chip_if_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int LEVEL_W        = DEF_LEVEL_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       chip_clk,
    input  logic                       chip_rst,
    input  logic                       chip_data_in,
    output logic                       frame_valid,
    output logic [ADDR_W-1:0]          frame_addr,
    output logic [LEVEL_W-1:0]         frame_level,
    output logic                       frame_err,
    output logic [1:0]                 err_code,
    output logic                       in_reset,
    output logic [8*LEVEL_W-1:0]       shadow_levels,
    output logic [15:0]                frame_count
);

    localparam int SH_W  = ADDR_W + LEVEL_W;
    localparam int CNT_W = $clog2(LEVEL_W + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    // ------------------------------------------------------------------
    // Input synchronizers; only chip_clk needs its falling-edge pulse.
    // ------------------------------------------------------------------
    logic clk_sync, sample;
    logic rst_sync, unused_rst_fall;
    logic data_sync, unused_data_fall;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk (clk), .rst (rst), .d (chip_clk),
        .q   (clk_sync), .fall (sample)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_rst (
        .clk (clk), .rst (rst), .d (chip_rst),
        .q   (rst_sync), .fall (unused_rst_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk (clk), .rst (rst), .d (chip_data_in),
        .q   (data_sync), .fall (unused_data_fall)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 bit_cnt_q, bit_cnt_d;
    logic [SH_W-1:0]                  shift_q, shift_d;
    logic [TMO_W-1:0]                 tmo_q, tmo_d;
    logic [NUM_DAC-1:0][LEVEL_W-1:0]  shadow_q, shadow_d;
    logic [15:0]                      count_q, count_d;
    logic [ADDR_W-1:0]                addr_q, addr_d;
    logic [LEVEL_W-1:0]               level_q, level_d;
    logic                             valid_q, valid_d;
    logic                             err_q, err_d;
    logic [1:0]                       code_q, code_d;
    logic [2:0]                       wr_idx;

    // Bits shift in at the top and move right, so once all ADDR_W+LEVEL_W
    // bits are in, the first (address LSB) bit sits at position 0.
    assign wr_idx = 3'(shift_q[ADDR_W-1:0]);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        shadow_d  = shadow_q;
        count_d   = count_q;
        addr_d    = addr_q;
        level_d   = level_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        code_d    = ERR_NONE;

        if (!rst_sync) begin
            // Link reset beats any sampling event in the same cycle.
            state_d  = ST_RESET;
            shadow_d = '0;
            tmo_d    = '0;
            if (in_frame(state_q)) begin
                err_d  = 1'b1;
                code_d = ERR_ABORT;
            end
        end else begin
            case (state_q)
                ST_RESET: state_d = ST_IDLE;

                ST_IDLE: begin
                    if (sample && !data_sync) begin
                        state_d   = ST_ADDR;
                        bit_cnt_d = '0;
                        tmo_d     = '0;
                    end
                end

                ST_ADDR, ST_LEVEL, ST_STOP: begin
                    if (sample) begin
                        tmo_d = '0;
                        if (state_q == ST_STOP) begin
                            state_d = ST_IDLE;
                            if (data_sync) begin
                                valid_d          = 1'b1;
                                addr_d           = shift_q[ADDR_W-1:0];
                                level_d          = shift_q[SH_W-1:ADDR_W];
                                shadow_d[wr_idx] = shift_q[SH_W-1:ADDR_W];
                                count_d          = count_q + 16'd1;
                            end else begin
                                err_d  = 1'b1;
                                code_d = ERR_STOP;
                            end
                        end else begin
                            shift_d = {data_sync, shift_q[SH_W-1:1]};
                            if (state_q == ST_ADDR &&
                                bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                                state_d   = ST_LEVEL;
                                bit_cnt_d = '0;
                            end else if (state_q == ST_LEVEL &&
                                         bit_cnt_q == CNT_W'(LEVEL_W - 1)) begin
                                state_d   = ST_STOP;
                                bit_cnt_d = '0;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 1'b1;
                            end
                        end
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        // tmo_q counts non-sampling cycles minus one, so this
                        // is the TIMEOUT_CYCLES-th cycle since the last edge.
                        state_d = ST_IDLE;
                        tmo_d   = '0;
                        err_d   = 1'b1;
                        code_d  = ERR_TIMEOUT;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RESET;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tmo_q     <= '0;
            shadow_q  <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            level_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
            shadow_q  <= shadow_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            level_q   <= level_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    assign frame_valid   = valid_q;
    assign frame_addr    = addr_q;
    assign frame_level   = level_q;
    assign frame_err     = err_q;
    assign err_code      = code_q;
    assign in_reset      = ~rst_sync;
    assign shadow_levels = shadow_q;
    assign frame_count   = count_q;

    // clk_sync is only needed for its edge pulse.
    logic unused_clk_sync;
    assign unused_clk_sync = clk_sync;

endmodule
`default_nettype wire

// File: tb/tb_chip_serial_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_chip_serial_rx
// Purpose  : Self-checking bench for chip_serial_rx. Frames and expected
//            errors are queued as they are driven and compared when the
//            receiver reports them, against a bench-side shadow/count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chip_serial_rx;
    import chip_if_pkg::*;

    localparam int SYNC   = 2;
    localparam int TMO    = 8192;
    localparam int HALF   = 8;          // chip_clk half period in clk cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        chip_clk = 1'b0;
    logic        chip_rst = 1'b1;
    logic        chip_data_in = 1'b1;
    logic        frame_valid;
    logic [2:0]  frame_addr;
    logic [7:0]  frame_level;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        in_reset;
    logic [63:0] shadow_levels;
    logic [15:0] frame_count;

    chip_serial_rx #(
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TMO),
        .ADDR_W         (3),
        .LEVEL_W        (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .chip_clk      (chip_clk),
        .chip_rst      (chip_rst),
        .chip_data_in  (chip_data_in),
        .frame_valid   (frame_valid),
        .frame_addr    (frame_addr),
        .frame_level   (frame_level),
        .frame_err     (frame_err),
        .err_code      (err_code),
        .in_reset      (in_reset),
        .shadow_levels (shadow_levels),
        .frame_count   (frame_count)
    );

    always #2.5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [10:0] exp_frm_q[$];   // {addr, level}
    logic [1:0]  exp_err_q[$];
    logic [63:0] m_shadow = '0;
    logic [15:0] m_cnt    = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- output monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) begin
                chk("valid_err_exclusive", {63'd0, frame_err}, 64'd0);
                if (exp_frm_q.size() == 0) begin
                    chk("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    logic [10:0] e;
                    e = exp_frm_q.pop_front();
                    chk("frame_addr", {61'd0, frame_addr}, {61'd0, e[10:8]});
                    chk("frame_level", {56'd0, frame_level}, {56'd0, e[7:0]});
                    m_shadow[e[10:8]*8 +: 8] = e[7:0];
                    m_cnt = m_cnt + 16'd1;
                    chk("shadow_on_valid", shadow_levels, m_shadow);
                    chk("count_on_valid", {48'd0, frame_count}, {48'd0, m_cnt});
                end
            end
            if (frame_err) begin
                if (exp_err_q.size() == 0) begin
                    chk("unexpected_err", {62'd0, err_code}, 64'd0);
                end else begin
                    logic [1:0] ec;
                    ec = exp_err_q.pop_front();
                    chk("err_code", {62'd0, err_code}, {62'd0, ec});
                    if (ec == ERR_ABORT) m_shadow = '0;
                    chk("shadow_on_err", shadow_levels, m_shadow);
                    chk("count_on_err", {48'd0, frame_count}, {48'd0, m_cnt});
                end
            end
        end
    end

    // ---------------- link stimulus ----------------
    task automatic send_bit(input logic b);
        @(negedge clk);
        chip_clk     = 1'b1;
        chip_data_in = b;
        repeat (HALF) @(negedge clk);
        chip_clk = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_frame(input logic [2:0] a, input logic [7:0] l, input logic stop);
        if (stop) exp_frm_q.push_back({a, l});
        else      exp_err_q.push_back(ERR_STOP);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(a[i]);
        for (int i = 0; i < 8; i++) send_bit(l[i]);
        send_bit(stop);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {63'd0, frame_valid}, 64'd0);
        chk({tag, "_err"},   {63'd0, frame_err}, 64'd0);
        chk({tag, "_code"},  {62'd0, err_code}, 64'd0);
        chk({tag, "_addr"},  {61'd0, frame_addr}, 64'd0);
        chk({tag, "_level"}, {56'd0, frame_level}, 64'd0);
        chk({tag, "_shadow"}, shadow_levels, 64'd0);
        chk({tag, "_count"}, {48'd0, frame_count}, 64'd0);
        chk({tag, "_in_reset"}, {63'd0, in_reset}, 64'd1);
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] lv;
        logic [2:0] ad;

        // Reset
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("in_reset_released", {63'd0, in_reset}, 64'd0);

        // 1: single frame
        send_frame(3'd5, 8'hA3, 1'b1);
        repeat (HALF) @(negedge clk);
        chk("t1_shadow", shadow_levels, 64'h0000_A300_0000_0000);
        chk("t1_count", {48'd0, frame_count}, 64'd1);

        // 2: back-to-back frame, then one idle bit, then another
        send_frame(3'd2, 8'h0F, 1'b1);
        send_bit(1'b1);
        send_frame(3'd7, 8'hFF, 1'b1);
        repeat (HALF) @(negedge clk);
        chk("t2_shadow", shadow_levels, 64'hFF00_A300_000F_0000);
        chk("t2_count", {48'd0, frame_count}, 64'd3);

        // 3: bad stop bit, then a good frame
        send_frame(3'd3, 8'h77, 1'b0);
        send_frame(3'd1, 8'h55, 1'b1);
        repeat (HALF) @(negedge clk);
        chk("t3_shadow", shadow_levels, 64'hFF00_A300_000F_5500);

        // 4: stall after the 4th level bit
        ad = 3'd6; lv = 8'h96;
        exp_err_q.push_back(ERR_TIMEOUT);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(ad[i]);
        for (int i = 0; i < 3; i++) send_bit(lv[i]);
        @(negedge clk);
        chip_clk = 1'b1;
        chip_data_in = lv[3];
        repeat (HALF) @(negedge clk);
        chip_clk = 1'b0;
        n = 0;
        while (n < 10000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (frame_err) break;
        end
        chk("t4_timeout_cycles", 64'(n), 64'(TMO + SYNC + 2));
        if (n < 10000) repeat (10000 - n) @(negedge clk);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        send_frame(3'd4, 8'h3C, 1'b1);
        repeat (HALF) @(negedge clk);
        chk("t4_count", {48'd0, frame_count}, {48'd0, m_cnt});

        // 5: link reset during address bit 1
        ad = 3'd2;
        exp_err_q.push_back(ERR_ABORT);
        send_bit(1'b0);
        send_bit(ad[0]);
        @(negedge clk);
        chip_clk = 1'b1;
        chip_data_in = ad[1];
        repeat (2) @(negedge clk);
        chip_rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_in_reset", {63'd0, in_reset}, 64'd1);
        chk("t5_shadow", shadow_levels, 64'd0);
        chk("t5_count", {48'd0, frame_count}, 64'd5);
        chip_clk = 1'b0;
        repeat (5) @(negedge clk);
        chip_rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("t5_in_reset_rel", {63'd0, in_reset}, 64'd0);

        // 6: async reset mid-frame
        ad = 3'd0; lv = 8'h12;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(ad[i]);
        send_bit(lv[0]);
        @(posedge clk);
        #1 rst = 1'b1;
        #0.5;
        chk_all_zero("t6_async");
        exp_frm_q.delete();
        exp_err_q.delete();
        m_shadow = '0;
        m_cnt    = '0;
        repeat (2) @(negedge clk);
        chip_clk = 1'b0;
        chip_data_in = 1'b1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        send_frame(3'd6, 8'h81, 1'b1);
        repeat (HALF) @(negedge clk);
        chk("t6_shadow", shadow_levels, 64'h0081_0000_0000_0000);
        chk("t6_count", {48'd0, frame_count}, 64'd1);

        repeat (40) @(negedge clk);
        chk("frames_pending", 64'(exp_frm_q.size()), 64'd0);
        chk("errors_pending", 64'(exp_err_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
